axi_data_transfer_regs: RTL and testbench
=========================================

# axi_data_transfer_regs

AXI4-Lite slave register file that terminates the master VIP's write/read bursts in the axi_data_transfer block. It holds NUM_REGS 32-bit read/write control registers with byte-strobe writes, OKAY/SLVERR responses and full per-channel back-pressure. Register contents are exported in parallel to the data-transfer datapath, with a one-cycle write strobe per register.

## Interface

Parameters:
- NUM_REGS, 4, number of 32-bit registers (2..16, power of two)
- ADDR_WIDTH, 6, AXI address width; byte address, word index = ADDR[ADDR_WIDTH-1:2]

Ports:
- ACLK  in  1  single clock; all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  accepted, ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables, bit n -> WDATA[8n+7:8n]
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  accepted, ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake
- reg_out  out  NUM_REGS*32  register r at [32r+31:32r]
- wr_pulse  out  NUM_REGS  one-cycle strobe, bit r high the cycle after register r is written

## Operation

- Reset (ARESET high at edge): all registers 0; AWREADY=WREADY=ARREADY=0 during reset, 1 the first cycle after ARESET deasserts; BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0; wr_pulse=0. Reset mid-transaction discards pending AW/W/B/R state; no partial write is committed.
- Write FSM states: W_IDLE (awaiting both AW and W), W_HAVE_AW, W_HAVE_W, W_RESP.
  - AWREADY high in W_IDLE and W_HAVE_W; WREADY high in W_IDLE and W_HAVE_AW; both low in W_RESP.
  - AW and W captured independently, any order, or both in the same cycle.
  - Commit on the edge completing the later handshake: index = captured AWADDR[ADDR_WIDTH-1:2]; if index < NUM_REGS, update only strobed bytes, BRESP=00, wr_pulse[index]=1 for the next cycle; else no register change, BRESP=10, no pulse. Enter W_RESP, BVALID=1.
  - W_RESP: BVALID/BRESP held stable until BREADY; on BVALID&BREADY return to W_IDLE.
  - WSTRB=0 to a valid index: OKAY, no data change, wr_pulse still fires.
- Read path, states R_IDLE, R_DATA:
  - ARREADY = !RVALID. On the AR handshake, RDATA = register[index] (or 0 with RRESP=10 if out of range); RVALID=1 next cycle.
  - RDATA/RRESP held stable until RREADY; on RVALID&RREADY go to R_IDLE.
- Read and write channels are fully independent. A read accepted on the same edge as a write commit to the same register returns the pre-write value.
- Address bits [1:0] are ignored; unaligned addresses are treated as word-aligned.
- At most one outstanding write and one outstanding read.

## Timing

- Write: AW and W both valid with BREADY=1 -> BVALID at cycle +1, readies back at +2; peak throughput 1 write per 2 cycles.
- Read: ARVALID at cycle 0 -> RVALID at +1; with RREADY=1, ARREADY back at +2; 1 read per 2 cycles.
- reg_out reflects a committed write in the cycle after the commit edge, coincident with BVALID and wr_pulse.
- No combinational path from any VALID/READY input to any output.

## Test plan

- Sequential: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read the same addresses -> all BRESP/RRESP=00; RDATA 0x1..0x4; reg_out=0x00000004_00000003_00000002_00000001.
- Strobes: write 0xAABBCCDD to 0x4, then 0x11223344 with WSTRB=0101 -> read 0x4 returns 0xAA22CC44; wr_pulse[1] high exactly one cycle per write.
- Ordering and back-pressure: present W 3 cycles before AW, hold BREADY low 5 cycles -> no commit until AW handshake; BVALID held 5 cycles; AWREADY/WREADY low throughout; next write accepted only after the B handshake.
- Out of range: write 0xDEADBEEF to 0x10, read 0x3C -> BRESP=10, no register changes, no wr_pulse; RRESP=10, RDATA=0.
- Same-edge collision: reg2=0x5, AR to 0x8 on the same edge as a write commit of 0x9 to 0x8 -> RDATA=0x5; a subsequent read returns 0x9.
- Reset mid-op: assert ARESET while BVALID=1 and RVALID=1 (RREADY low) -> next cycle BVALID=RVALID=0, reg_out=0; after release, the sequential test passes.

Source files
------------

// File: rtl/axi_data_transfer_regs.sv
// AXI4-Lite slave register file for the axi_data_transfer block: NUM_REGS 32-bit
// byte-strobed registers exported in parallel, with a one-cycle write strobe per register.
module axi_data_transfer_regs #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [31:0]                S_AXI_WDATA,
  input  logic [3:0]                 S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [31:0]                S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]     reg_out,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned SEL_W  = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  wstate_e           r_wstate;
  wstate_e           w_wstate_nxt;
  rstate_e           r_rstate;
  rstate_e           w_rstate_nxt;

  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic [IDX_W-1:0]  r_awidx;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;

  logic              r_arready;
  logic              r_rvalid;
  logic [1:0]        r_rresp;
  logic [DATA_W-1:0] r_rdata;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_commit;
  logic [IDX_W-1:0]  w_widx;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;
  logic [SEL_W-1:0]  w_wsel;
  logic              w_win;
  logic [IDX_W-1:0]  w_ridx;
  logic [SEL_W-1:0]  w_rsel;
  logic              w_rin;
  logic              w_unused;

  assign w_aw_hs = S_AXI_AWVALID && r_awready;
  assign w_w_hs  = S_AXI_WVALID  && r_wready;
  assign w_b_hs  = r_bvalid      && S_AXI_BREADY;
  assign w_ar_hs = S_AXI_ARVALID && r_arready;
  assign w_r_hs  = r_rvalid      && S_AXI_RREADY;

  // Commit uses whichever half arrives this edge, else the captured copy
  assign w_widx  = w_aw_hs ? S_AXI_AWADDR[ADDR_WIDTH-1:2] : r_awidx;
  assign w_wdata = w_w_hs  ? S_AXI_WDATA : r_wdata;
  assign w_wstrb = w_w_hs  ? S_AXI_WSTRB : r_wstrb;
  assign w_wsel  = w_widx[SEL_W-1:0];
  assign w_win   = (32'(w_widx) < NUM_REGS);

  assign w_ridx  = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign w_rsel  = w_ridx[SEL_W-1:0];
  assign w_rin   = (32'(w_ridx) < NUM_REGS);

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  // Write FSM next state and commit decision
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_commit     = 1'b1;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_commit     = 1'b1;
        end
      end
      W_HAVE_W: begin
        if (w_aw_hs) begin
          w_wstate_nxt = W_RESP;
          w_commit     = 1'b1;
        end
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write channel outputs, capture registers and response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
      r_awidx    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      r_awready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_W);
      r_wready   <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_AW);
      r_wr_pulse <= '0;
      if (w_aw_hs) begin
        r_awidx <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_win ? RESP_OKAY : RESP_SLVERR;
        if (w_win) begin
          r_wr_pulse[w_wsel] <= 1'b1;
        end
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register storage; out-of-range commits leave every register untouched
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_regs <= '{default: '0};
    end else if (w_commit && w_win) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_wstrb[b]) begin
          r_regs[w_wsel][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read data sampled from pre-commit register values on the AR edge
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_rdata <= w_rin ? r_regs[w_rsel] : '0;
        r_rresp <= w_rin ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign wr_pulse      = r_wr_pulse;

endmodule

// File: tb/tb_axi_data_transfer_regs.sv
// Self-checking bench for axi_data_transfer_regs: directed scenarios plus random
// traffic checked against an array model of the register file.
module tb_axi_data_transfer_regs;

  localparam int unsigned NUM_REGS   = 4;
  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned RW         = NUM_REGS * 32;

  logic                    ACLK = 1'b0;
  logic                    ARESET = 1'b1;
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR = '0;
  logic [2:0]              S_AXI_AWPROT = '0;
  logic                    S_AXI_AWVALID = 1'b0;
  logic                    S_AXI_AWREADY;
  logic [31:0]             S_AXI_WDATA = '0;
  logic [3:0]              S_AXI_WSTRB = '0;
  logic                    S_AXI_WVALID = 1'b0;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY = 1'b0;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR = '0;
  logic [2:0]              S_AXI_ARPROT = '0;
  logic                    S_AXI_ARVALID = 1'b0;
  logic                    S_AXI_ARREADY;
  logic [31:0]             S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY = 1'b0;
  logic [RW-1:0]           reg_out;
  logic [NUM_REGS-1:0]     wr_pulse;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [NUM_REGS];

  axi_data_transfer_regs #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] model_regout();
    logic [RW-1:0] v;
    for (int r = 0; r < NUM_REGS; r++) v[r*32 +: 32] = m_regs[r];
    return v;
  endfunction

  // One write; AW/W raised after independent delays, BREADY after b_dly cycles
  task automatic axi_write(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    bit aw_done;
    bit w_done;
    int cyc;
    int word;
    logic [1:0] exp_resp;
    logic [NUM_REGS-1:0] exp_pulse;
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    word    = int'(addr) / 4;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    S_AXI_BREADY = 1'b0;
    while (!(aw_done && w_done)) begin
      if (cyc > 64) begin
        check_eq("write_accept_timeout", RW'({aw_done, w_done}), RW'(2'b11));
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        return;
      end
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      if (aw_done) check_eq("awready_after_aw", RW'(S_AXI_AWREADY), RW'(0));
      if (w_done)  check_eq("wready_after_w", RW'(S_AXI_WREADY), RW'(0));
      check_eq("bvalid_before_commit", RW'(S_AXI_BVALID), RW'(0));
      check_eq("regout_before_commit", reg_out, model_regout());
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY)   w_done = 1;
      @(negedge ACLK);
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    exp_pulse = '0;
    if (word < NUM_REGS) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_regs[word][8*b +: 8] = data[8*b +: 8];
      exp_pulse[word] = 1'b1;
      exp_resp = 2'b00;
    end else begin
      exp_resp = 2'b10;
    end
    check_eq("bvalid_after_commit", RW'(S_AXI_BVALID), RW'(1));
    check_eq("bresp", RW'(S_AXI_BRESP), RW'(exp_resp));
    check_eq("wr_pulse_on_commit", RW'(wr_pulse), RW'(exp_pulse));
    check_eq("regout_after_commit", reg_out, model_regout());
    check_eq("awready_in_resp", RW'(S_AXI_AWREADY), RW'(0));
    check_eq("wready_in_resp", RW'(S_AXI_WREADY), RW'(0));
    for (int i = 0; i < b_dly; i++) begin
      @(negedge ACLK);
      check_eq("bvalid_held", RW'(S_AXI_BVALID), RW'(1));
      check_eq("bresp_held", RW'(S_AXI_BRESP), RW'(exp_resp));
      check_eq("wr_pulse_single", RW'(wr_pulse), RW'(0));
      check_eq("aw_wready_blocked", RW'({S_AXI_AWREADY, S_AXI_WREADY}), RW'(0));
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check_eq("bvalid_after_bhs", RW'(S_AXI_BVALID), RW'(0));
    check_eq("readies_after_bhs", RW'({S_AXI_AWREADY, S_AXI_WREADY}), RW'(2'b11));
    check_eq("wr_pulse_after", RW'(wr_pulse), RW'(0));
  endtask

  // One read; expected data taken from the model at the AR handshake
  task automatic axi_read(input logic [ADDR_WIDTH-1:0] addr, input int ar_dly, input int r_dly);
    bit done;
    int cyc;
    int word;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    done     = 0;
    cyc      = 0;
    word     = int'(addr) / 4;
    exp_data = '0;
    exp_resp = 2'b00;
    S_AXI_ARADDR = addr;
    S_AXI_RREADY = 1'b0;
    while (!done) begin
      if (cyc > 64) begin
        check_eq("read_accept_timeout", RW'(done), RW'(1));
        S_AXI_ARVALID = 1'b0;
        return;
      end
      S_AXI_ARVALID = (cyc >= ar_dly);
      check_eq("rvalid_before_ar", RW'(S_AXI_RVALID), RW'(0));
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        done = 1;
        if (word < NUM_REGS) begin
          exp_data = m_regs[word];
          exp_resp = 2'b00;
        end else begin
          exp_data = '0;
          exp_resp = 2'b10;
        end
      end
      @(negedge ACLK);
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i <= r_dly; i++) begin
      if (i > 0) @(negedge ACLK);
      check_eq("rvalid", RW'(S_AXI_RVALID), RW'(1));
      check_eq("arready_busy", RW'(S_AXI_ARREADY), RW'(0));
      check_eq("rdata", RW'(S_AXI_RDATA), RW'(exp_data));
      check_eq("rresp", RW'(S_AXI_RRESP), RW'(exp_resp));
    end
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    check_eq("rvalid_after_rhs", RW'(S_AXI_RVALID), RW'(0));
    check_eq("arready_after_rhs", RW'(S_AXI_ARREADY), RW'(1));
  endtask

  task automatic run_sequential();
    for (int i = 0; i < 4; i++)
      axi_write(ADDR_WIDTH'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      axi_read(ADDR_WIDTH'(i * 4), 0, 0);
    check_eq("seq_regout", reg_out, 128'h00000004_00000003_00000002_00000001);
  endtask

  logic [ADDR_WIDTH-1:0] ra;

  initial begin
    for (int r = 0; r < NUM_REGS; r++) m_regs[r] = '0;

    // Reset state
    repeat (3) @(negedge ACLK);
    check_eq("rst_readies", RW'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), RW'(0));
    check_eq("rst_valids", RW'({S_AXI_BVALID, S_AXI_RVALID}), RW'(0));
    check_eq("rst_resps", RW'({S_AXI_BRESP, S_AXI_RRESP}), RW'(0));
    check_eq("rst_rdata", RW'(S_AXI_RDATA), RW'(0));
    check_eq("rst_wr_pulse", RW'(wr_pulse), RW'(0));
    check_eq("rst_regout", reg_out, model_regout());
    ARESET = 1'b0;
    @(negedge ACLK);
    check_eq("post_rst_readies", RW'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), RW'(3'b111));

    run_sequential();

    // Byte strobes, including an empty strobe that still pulses
    axi_write(6'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    axi_write(6'h04, 32'h11223344, 4'b0101, 0, 0, 2);
    check_eq("strobe_reg1", RW'(reg_out[63:32]), RW'(32'hAA22CC44));
    axi_read(6'h04, 0, 0);
    axi_write(6'h05, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    axi_read(6'h07, 1, 1);

    // W leads AW by 3 cycles, BREADY held low 5 cycles
    axi_write(6'h08, 32'h0BADF00D, 4'hF, 3, 0, 5);
    axi_write(6'h0C, 32'hCAFE0001, 4'hF, 0, 2, 1);

    // Out-of-range write and read
    axi_write(6'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(6'h3C, 0, 0);

    // Read accepted on the same edge as a write commit to the same register
    axi_write(6'h08, 32'h5, 4'hF, 0, 0, 0);
    fork
      axi_write(6'h08, 32'h9, 4'hF, 0, 0, 0);
      axi_read(6'h08, 0, 0);
    join
    axi_read(6'h08, 0, 0);
    check_eq("collision_reg2", RW'(reg_out[95:64]), RW'(32'h9));

    // Random traffic
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 3) == 0) ra = ADDR_WIDTH'($urandom_range(0, 63));
      else                           ra = ADDR_WIDTH'($urandom_range(0, NUM_REGS * 4 - 1));
      if ($urandom_range(0, 1) == 1)
        axi_write(ra, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        axi_read(ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Reset while both a write response and read data are pending
    S_AXI_AWADDR  = 6'h00;
    S_AXI_WDATA   = 32'h77;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_ARADDR  = 6'h04;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    check_eq("midop_pending", RW'({S_AXI_BVALID, S_AXI_RVALID}), RW'(2'b11));
    ARESET = 1'b1;
    @(negedge ACLK);
    for (int r = 0; r < NUM_REGS; r++) m_regs[r] = '0;
    check_eq("midop_valids", RW'({S_AXI_BVALID, S_AXI_RVALID}), RW'(0));
    check_eq("midop_regout", reg_out, model_regout());
    check_eq("midop_wr_pulse", RW'(wr_pulse), RW'(0));
    check_eq("midop_readies", RW'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), RW'(0));
    ARESET = 1'b0;
    @(negedge ACLK);
    check_eq("midop_readies_back", RW'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), RW'(3'b111));
    run_sequential();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
